// File: rtl/conv1x1_seq_mac.sv
// Pointwise 1x1 convolution: N_OUT parallel MACs walk one input channel per cycle, coefficients loaded at runtime.
// Result valid N_IN+1 cycles after acceptance; in_ready stays low until the result is handshaken.
module conv1x1_seq_mac #(
   parameter int DATAW = 32,
   parameter int FRAC  = 16,
   parameter int N_IN  = 12,
   parameter int N_OUT = 4,
   parameter int RELU  = 0,
   parameter int IMG_W = 3,
   parameter int IMG_H = 3,
   localparam int NCOEF = N_OUT * (N_IN + 1),
   localparam int AW    = $clog2(NCOEF)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_IN*DATAW-1:0]  in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N_OUT*DATAW-1:0] out_data,
   output logic                   frame_done,
   input  logic                   cfg_wr,
   input  logic [AW-1:0]          cfg_addr,
   input  logic [DATAW-1:0]       cfg_data,
   output logic                   cfg_err
);
   localparam int ACCW = 2*DATAW + $clog2(N_IN+1);
   localparam int CHW  = $clog2(N_IN+1);
   localparam int NPIX = IMG_W * IMG_H;
   localparam int PW   = $clog2(NPIX+1);
   localparam logic [AW:0] NCOEF_V = NCOEF[AW:0];
   localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DATAW+1){1'b0}}, {(DATAW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] SMIN = ~SMAX;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_FIN, S_OUT} state_t;

   state_t                        state_q, state_d;
   logic [CHW-1:0]                ch_q, ch_d;
   logic [N_IN*DATAW-1:0]         data_q, data_d;
   logic [N_OUT-1:0][ACCW-1:0]    acc_q, acc_d;
   logic [NCOEF-1:0][DATAW-1:0]   coef_q;
   logic                          ovr_vld_q, ovr_vld_d;
   logic [AW-1:0]                 ovr_addr_q, ovr_addr_d;
   logic [DATAW-1:0]              ovr_dat_q, ovr_dat_d;
   logic [N_OUT*DATAW-1:0]        out_data_q, out_data_d;
   logic [PW-1:0]                 pix_q, pix_d;
   logic                          frame_done_q, frame_done_d;
   logic                          cfg_err_q, cfg_err_d;

   logic                          accept, cfg_ok;
   logic [AW-1:0]                 widx;
   logic signed [DATAW-1:0]       xv, wv;
   logic signed [2*DATAW-1:0]     prod;
   logic signed [ACCW-1:0]        sh;
   logic [DATAW-1:0]              res;
   logic [ACCW-1:0]               bext;

   assign in_ready   = (state_q == S_IDLE) && !rst;
   assign out_valid  = (state_q == S_OUT);
   assign out_data   = out_data_q;
   assign frame_done = frame_done_q;
   assign cfg_err    = cfg_err_q;
   assign accept     = in_valid && in_ready;
   assign cfg_ok     = cfg_wr && (state_q == S_IDLE) && ({1'b0, cfg_addr} < NCOEF_V);

   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      data_d       = data_q;
      acc_d        = acc_q;
      ovr_vld_d    = ovr_vld_q;
      ovr_addr_d   = ovr_addr_q;
      ovr_dat_d    = ovr_dat_q;
      out_data_d   = out_data_q;
      pix_d        = pix_q;
      frame_done_d = 1'b0;
      cfg_err_d    = cfg_wr && !cfg_ok;
      xv           = data_q[ch_q*DATAW +: DATAW];
      wv           = '0;
      widx         = '0;
      prod         = '0;
      sh           = '0;
      res          = '0;
      bext         = '0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_ACC;
               ch_d    = '0;
               data_d  = in_data;
               for (int k = 0; k < N_OUT; k++) begin
                  bext     = {{(ACCW-DATAW){coef_q[k*(N_IN+1)+N_IN][DATAW-1]}}, coef_q[k*(N_IN+1)+N_IN]};
                  acc_d[k] = bext << FRAC;
               end
               // A write landing on the accept edge must not be seen by this pixel: keep the old word.
               ovr_vld_d  = cfg_ok;
               ovr_addr_d = cfg_addr;
               ovr_dat_d  = coef_q[cfg_addr];
            end
         end
         S_ACC: begin
            for (int k = 0; k < N_OUT; k++) begin
               widx     = AW'(k*(N_IN+1)) + AW'(ch_q);
               wv       = (ovr_vld_q && (ovr_addr_q == widx)) ? ovr_dat_q : coef_q[widx];
               prod     = xv * wv;
               acc_d[k] = acc_q[k] + {{(ACCW-2*DATAW){prod[2*DATAW-1]}}, prod};
            end
            ch_d = ch_q + 1'b1;
            if (ch_q == CHW'(N_IN-1)) state_d = S_FIN;
         end
         S_FIN: begin
            for (int k = 0; k < N_OUT; k++) begin
               sh = $signed(acc_q[k]) >>> FRAC;
               if (sh > SMAX)      res = SMAX[DATAW-1:0];
               else if (sh < SMIN) res = SMIN[DATAW-1:0];
               else                res = sh[DATAW-1:0];
               if (RELU != 0 && res[DATAW-1]) res = '0;
               out_data_d[k*DATAW +: DATAW] = res;
            end
            state_d = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
               if (pix_q == PW'(NPIX-1)) begin
                  pix_d        = '0;
                  frame_done_d = 1'b1;
               end else begin
                  pix_d = pix_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ch_q         <= '0;
         data_q       <= '0;
         acc_q        <= '0;
         coef_q       <= '0;
         ovr_vld_q    <= 1'b0;
         ovr_addr_q   <= '0;
         ovr_dat_q    <= '0;
         out_data_q   <= '0;
         pix_q        <= '0;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         data_q       <= data_d;
         acc_q        <= acc_d;
         ovr_vld_q    <= ovr_vld_d;
         ovr_addr_q   <= ovr_addr_d;
         ovr_dat_q    <= ovr_dat_d;
         out_data_q   <= out_data_d;
         pix_q        <= pix_d;
         frame_done_q <= frame_done_d;
         cfg_err_q    <= cfg_err_d;
         if (cfg_ok) coef_q[cfg_addr] <= cfg_data;
      end
   end
endmodule

// File: tb/tb_conv1x1_seq_mac.sv
// Bench for conv1x1_seq_mac: directed cases with literal results, then randomized traffic against a behavioural model.
module tb_conv1x1_seq_mac;
   localparam int DW = 32, NI = 12, NO = 4, NC = NO*(NI+1), AW = $clog2(NC);
   localparam int LAT = NI + 2;   // negedges from the accept-cycle sample to the first sample showing out_valid
   localparam int NPIX = 9;
   localparam logic signed [95:0] MAXV = 96'sd2147483647;
   localparam logic signed [95:0] MINV = -96'sd2147483648;

   logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, cfg_wr = 0;
   logic [NI*DW-1:0] in_data = '0;
   logic [AW-1:0]    cfg_addr = '0;
   logic [DW-1:0]    cfg_data = '0;
   logic in_ready, out_valid, frame_done, cfg_err;
   logic in_ready_r, out_valid_r, frame_done_r, cfg_err_r;
   logic [NO*DW-1:0] out_data, out_data_r;
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   conv1x1_seq_mac dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .frame_done(frame_done),
      .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err));

   conv1x1_seq_mac #(.RELU(1)) dut_relu (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
      .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r), .frame_done(frame_done_r),
      .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err_r));

   task automatic chk1(input string nm, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin fails++; $display("FAIL %s: got %b expected %b", nm, act, exp); end
   endtask
   task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin fails++; $display("FAIL %s: got %h expected %h", nm, act, exp); end
   endtask
   task automatic chki(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin fails++; $display("FAIL %s: got %0d expected %0d", nm, act, exp); end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] mcoef [NC];
   int ncyc = 0, acc_cyc = 0, pix_cnt = 0, hs_cnt = 0, fd_cnt = 0, fd_at_hs = 0, err_cnt = 0;
   bit busy = 0, exp_fd = 0, exp_err = 0, ov_m, idle_m;
   logic [NO*DW-1:0] exp_d = '0, exp_r = '0, last_out = '0, last_out_r = '0;

   function automatic logic signed [95:0] sx(input logic [DW-1:0] v);
      return {{64{v[DW-1]}}, v};
   endfunction

   // Real-valued sum in Q16: floor to integer, clamp to 32-bit range, optional ReLU.
   function automatic logic [DW-1:0] ref_out(input int k, input logic [NI*DW-1:0] din, input bit relu);
      logic signed [95:0] s, q;
      logic [DW-1:0] r;
      s = sx(mcoef[k*(NI+1)+NI]) * 96'sd65536;
      for (int c = 0; c < NI; c++) s = s + sx(din[c*DW +: DW]) * sx(mcoef[k*(NI+1)+c]);
      q = s / 96'sd65536;
      if (s < 0 && (s % 96'sd65536) != 0) q = q - 96'sd1;
      if (q > MAXV)      r = 32'h7FFFFFFF;
      else if (q < MINV) r = 32'h80000000;
      else               r = q[DW-1:0];
      if (relu && r[DW-1]) r = '0;
      return r;
   endfunction

   always @(negedge clk) begin
      ncyc++;
      if (rst) begin
         chk1("in_ready_in_reset", in_ready, 1'b0);
         chk1("in_ready_in_reset_relu", in_ready_r, 1'b0);
         busy = 0; pix_cnt = 0; exp_fd = 0; exp_err = 0;
         for (int i = 0; i < NC; i++) mcoef[i] = '0;
      end else begin
         ov_m = busy && (ncyc - acc_cyc >= LAT);
         chk1("in_ready", in_ready, !busy);
         chk1("in_ready_relu", in_ready_r, !busy);
         chk1("out_valid", out_valid, ov_m);
         chk1("out_valid_relu", out_valid_r, ov_m);
         chk1("frame_done", frame_done, exp_fd);
         chk1("frame_done_relu", frame_done_r, exp_fd);
         chk1("cfg_err", cfg_err, exp_err);
         chk1("cfg_err_relu", cfg_err_r, exp_err);
         if (ov_m) begin
            chkv("out_data", out_data, exp_d);
            chkv("out_data_relu", out_data_r, exp_r);
         end
         if (frame_done) begin fd_cnt++; fd_at_hs = hs_cnt; end
         if (cfg_err) err_cnt++;
         exp_fd = 0; exp_err = 0;
         idle_m = !busy;
         if (in_valid && idle_m) begin
            for (int k = 0; k < NO; k++) begin
               exp_d[k*DW +: DW] = ref_out(k, in_data, 1'b0);
               exp_r[k*DW +: DW] = ref_out(k, in_data, 1'b1);
            end
            busy = 1; acc_cyc = ncyc;
         end else if (ov_m && out_ready) begin
            busy = 0; hs_cnt++;
            last_out = out_data; last_out_r = out_data_r;
            pix_cnt++;
            if (pix_cnt == NPIX) begin exp_fd = 1; pix_cnt = 0; end
         end
         if (cfg_wr) begin
            if (idle_m && int'(cfg_addr) < NC) mcoef[cfg_addr] = cfg_data;
            else exp_err = 1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(); @(posedge clk); #1; endtask

   task automatic cfg_write(input int a, input logic [DW-1:0] d);
      cfg_wr = 1; cfg_addr = AW'(a); cfg_data = d; step(); cfg_wr = 0;
   endtask

   task automatic send_pixel(input logic [NI*DW-1:0] d);
      bit ok;
      ok = 0; in_valid = 1; in_data = d;
      for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk); ok = in_ready; step(); end
      in_valid = 0;
      chk1("accept_timeout", ok, 1'b1);
   endtask

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int i = 0; i < 400 && !done; i++) begin @(negedge clk); #1; done = !busy; end
      chk1("idle_timeout", done, 1'b1);
      repeat (2) step();
   endtask

   function automatic logic [NI*DW-1:0] fill(input logic [DW-1:0] v);
      logic [NI*DW-1:0] r;
      for (int c = 0; c < NI; c++) r[c*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_coef();
      if ($urandom_range(0, 3) == 0) return $urandom;
      return 32'($urandom_range(0, 32'h7FFFF)) - 32'h40000;
   endfunction

   function automatic logic [NI*DW-1:0] rand_vec();
      logic [NI*DW-1:0] r;
      for (int c = 0; c < NI; c++) r[c*DW +: DW] = rand_coef();
      return r;
   endfunction

   task automatic load_unit();
      for (int k = 0; k < NO; k++)
         for (int c = 0; c < NI; c++) cfg_write(k*(NI+1)+c, 32'h00010000);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NI*DW-1:0] ones;
      int h0, e0;
      bit taken;
      ones = fill(32'h00010000);
      repeat (3) step();
      rst = 0;
      @(negedge clk); #1;
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_out_valid", out_valid, 1'b0);
      chkv("rst_out_data", out_data, '0);
      chk1("rst_frame_done", frame_done, 1'b0);
      chk1("rst_cfg_err", cfg_err, 1'b0);
      step();

      load_unit();
      send_pixel(ones); wait_idle();
      chkv("unit_sum", last_out, {4{32'h000C0000}});

      // write to weight 0 on the same edge the pixel is accepted
      in_valid = 1; in_data = ones; cfg_wr = 1; cfg_addr = 0; cfg_data = 32'h00030000;
      step(); in_valid = 0; cfg_wr = 0;
      wait_idle();
      chkv("same_cycle_old_coef", last_out, {4{32'h000C0000}});
      send_pixel(ones); wait_idle();
      chkv("same_cycle_new_coef", last_out, {{3{32'h000C0000}}, 32'h000E0000});
      cfg_write(0, 32'h00010000);

      cfg_write(2*(NI+1)+NI, 32'h00008000);
      for (int c = 0; c < NI; c++) cfg_write(2*(NI+1)+c, 32'h00020000);
      send_pixel(ones); wait_idle();
      chkv("filter2_bias", last_out, {32'h000C0000, 32'h00188000, 32'h000C0000, 32'h000C0000});

      send_pixel(fill(32'h7FFF0000)); wait_idle();
      chkv("sat_pos", last_out, {4{32'h7FFFFFFF}});
      chkv("sat_pos_relu", last_out_r, {4{32'h7FFFFFFF}});
      send_pixel(fill(32'h80000000)); wait_idle();
      chkv("sat_neg", last_out, {4{32'h80000000}});
      chkv("sat_neg_relu", last_out_r, '0);

      out_ready = 0;
      send_pixel(ones);
      repeat (NI + 22) step();
      chk1("stall_in_ready", in_ready, 1'b0);
      chk1("stall_out_valid", out_valid, 1'b1);
      out_ready = 1;
      wait_idle();
      chkv("stall_data", last_out, {32'h000C0000, 32'h00188000, 32'h000C0000, 32'h000C0000});

      rst = 1; repeat (2) step(); rst = 0;
      load_unit();
      h0 = hs_cnt; e0 = fd_cnt;
      for (int p = 0; p < NPIX; p++) send_pixel(rand_vec());
      wait_idle();
      chki("frame_pulses", fd_cnt - e0, 1);
      chki("frame_pulse_at_9th", fd_at_hs - h0, NPIX);
      send_pixel(ones); wait_idle();
      chki("frame_no_extra_pulse", fd_cnt - e0, 1);

      e0 = err_cnt;
      send_pixel(ones);
      repeat (3) step();
      cfg_write(5, 32'hDEAD0000);
      wait_idle();
      cfg_write(NC, 32'h12345678);
      step();
      chki("cfg_err_pulses", err_cnt - e0, 2);
      send_pixel(ones); wait_idle();
      chkv("coef_kept", last_out, {4{32'h000C0000}});

      send_pixel(ones);
      repeat (4) step();
      rst = 1; repeat (2) step(); rst = 0;
      @(negedge clk); #1;
      chk1("post_rst_in_ready", in_ready, 1'b1);
      chk1("post_rst_out_valid", out_valid, 1'b0);
      step();
      repeat (20) step();
      send_pixel(ones); wait_idle();
      chkv("rst_clears_coef", last_out, '0);

      for (int i = 0; i < NC; i++) cfg_write(i, rand_coef());
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk); taken = in_valid && in_ready;
         step();
         if (taken || !in_valid) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = rand_vec();
         end
         out_ready = ($urandom_range(0, 3) != 0);
         cfg_wr    = ($urandom_range(0, 9) == 0);
         cfg_addr  = AW'($urandom_range(0, (1 << AW) - 1));
         cfg_data  = rand_coef();
      end
      in_valid = 0; cfg_wr = 0; out_ready = 1;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
